// File: rtl/cajero_pkg.sv
// Shared key codes, debounce states and key map for the ATM keypad.
// Imported by teclado_scan and teclado_cajero.
package cajero_pkg;

  typedef logic [4:0] tecla_t;

  localparam tecla_t TECLA_0       = 5'd0;
  localparam tecla_t TECLA_1       = 5'd1;
  localparam tecla_t TECLA_2       = 5'd2;
  localparam tecla_t TECLA_3       = 5'd3;
  localparam tecla_t TECLA_4       = 5'd4;
  localparam tecla_t TECLA_5       = 5'd5;
  localparam tecla_t TECLA_6       = 5'd6;
  localparam tecla_t TECLA_7       = 5'd7;
  localparam tecla_t TECLA_8       = 5'd8;
  localparam tecla_t TECLA_9       = 5'd9;
  localparam tecla_t TECLA_A       = 5'hA;
  localparam tecla_t TECLA_B       = 5'hB;
  localparam tecla_t TECLA_C       = 5'hC;
  localparam tecla_t TECLA_D       = 5'hD;
  localparam tecla_t TECLA_ENTER   = 5'hE;
  localparam tecla_t TECLA_BORRAR  = 5'hF;
  // All 16 keys use 4-bit codes, so "no key" needs the fifth bit.
  localparam tecla_t TECLA_NINGUNA = 5'h10;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } deb_t;

  // Indexed by {row, col}.
  localparam tecla_t MAPA [16] = '{
    TECLA_1,      TECLA_2, TECLA_3,     TECLA_A,
    TECLA_4,      TECLA_5, TECLA_6,     TECLA_B,
    TECLA_7,      TECLA_8, TECLA_9,     TECLA_C,
    TECLA_BORRAR, TECLA_0, TECLA_ENTER, TECLA_D
  };

  function automatic tecla_t tecla_de(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return MAPA[{r, c}];
  endfunction

  function automatic logic es_digito(input tecla_t t);
    return t <= TECLA_9;
  endfunction

endpackage

// File: rtl/teclado_scan.sv
// Keypad matrix scanner: row synchronizer, column rotation, row decode.
// Ports: clock/reset, columnas (out), filas (in), scan_valid, scan_code.
module teclado_scan
  import cajero_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] columnas,
  input  logic [3:0] filas,
  output logic       scan_valid,
  output logic [4:0] scan_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div;
  logic [1:0]    col;
  logic          last;
  logic [3:0]    f1, f2;
  logic          last_d1, last_d2;
  logic [1:0]    col_d1, col_d2;
  logic [1:0]    hits;
  tecla_t        code;

  logic [3:0] act;
  logic [2:0] n;
  logic [1:0] row;
  logic [1:0] base;
  logic [2:0] sum;
  logic [1:0] hits_nx;
  tecla_t     code_nx;
  tecla_t     fin;

  assign last     = (div == DW'(SCAN_DIV - 1));
  assign columnas = ~(4'b0001 << col);

  // Rows seen on the last dwell cycle come out of the
  // synchronizer two cycles later, so the column tag and the
  // sample strobe are delayed by the same amount.
  always_comb begin
    act = ~f2;
    n   = 3'd0;
    row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (act[r]) begin
        n   = n + 3'd1;
        row = 2'(r);
      end
    end
    base    = (col_d2 == 2'd0) ? 2'd0 : hits;
    sum     = {1'b0, base} + n;
    hits_nx = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    if (n == 3'd1)
      code_nx = tecla_de(row, col_d2);
    else if (col_d2 == 2'd0)
      code_nx = TECLA_NINGUNA;
    else
      code_nx = code;
    fin = (hits_nx == 2'd1) ? code_nx : TECLA_NINGUNA;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div        <= '0;
      col        <= 2'd0;
      f1         <= 4'hF;
      f2         <= 4'hF;
      last_d1    <= 1'b0;
      last_d2    <= 1'b0;
      col_d1     <= 2'd0;
      col_d2     <= 2'd0;
      hits       <= 2'd0;
      code       <= TECLA_NINGUNA;
      scan_valid <= 1'b0;
      scan_code  <= TECLA_NINGUNA;
    end else begin
      f1      <= filas;
      f2      <= f1;
      last_d1 <= last;
      last_d2 <= last_d1;
      col_d1  <= col;
      col_d2  <= col_d1;
      if (last) begin
        div <= '0;
        col <= col + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      scan_valid <= 1'b0;
      if (last_d2) begin
        hits <= hits_nx;
        code <= code_nx;
        if (col_d2 == 2'd3) begin
          scan_valid <= 1'b1;
          scan_code  <= fin;
        end
      end
    end
  end

endmodule

// File: rtl/teclado_cajero.sv
// ATM keypad front-end: debounce, PIN digit strobes, amount entry.
// Ports: clock/reset, COLUMNAS/FILAS matrix, MODO_MONTO, DIGITO_*, MONTO_*.
module teclado_cajero
  import cajero_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int MAX_DIG      = 8,
  parameter int MONTO_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic [3:0]         COLUMNAS,
  input  logic [3:0]         FILAS,
  input  logic               MODO_MONTO,
  output logic               DIGITO_STB,
  output logic [3:0]         DIGITO,
  output logic               MONTO_STB,
  output logic [MONTO_W-1:0] MONTO
);

  localparam int CW  = $clog2(DEBOUNCE_CNT + 1);
  localparam int DCW = $clog2(MAX_DIG + 1);

  logic   scan_valid;
  tecla_t scan_code;

  teclado_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .columnas  (COLUMNAS),
    .filas     (FILAS),
    .scan_valid(scan_valid),
    .scan_code (scan_code)
  );

  deb_t          st, st_nx;
  tecla_t        cand, cand_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ev;
  tecla_t        ev_code;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st   <= IDLE;
      cand <= TECLA_NINGUNA;
      cnt  <= '0;
    end else begin
      st   <= st_nx;
      cand <= cand_nx;
      cnt  <= cnt_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    cand_nx = cand;
    cnt_nx  = cnt;
    ev      = 1'b0;
    ev_code = cand;
    if (scan_valid) begin
      unique case (st)
        IDLE: begin
          if (scan_code != TECLA_NINGUNA) begin
            cand_nx = scan_code;
            if (DEBOUNCE_CNT <= 1) begin
              ev      = 1'b1;
              ev_code = scan_code;
              cnt_nx  = '0;
              st_nx   = PRESSED;
            end else begin
              cnt_nx = CW'(1);
              st_nx  = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (scan_code == cand) begin
            if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
              ev     = 1'b1;
              cnt_nx = '0;
              st_nx  = PRESSED;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else begin
            cnt_nx = '0;
            st_nx  = IDLE;
          end
        end
        PRESSED: begin
          // cnt counts consecutive empty scans toward release.
          if (scan_code == TECLA_NINGUNA) begin
            if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
              cnt_nx = '0;
              st_nx  = IDLE;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        default: begin
          cnt_nx = '0;
          st_nx  = IDLE;
        end
      endcase
    end
  end

  logic [MONTO_W-1:0] acc;
  logic [DCW-1:0]     dcnt;
  logic               modo_q;
  logic [MONTO_W-1:0] acc_nx;

  assign acc_nx = (acc << 3) + (acc << 1)
                + MONTO_W'(ev_code[3:0]);

  // modo_q is the mode that was in force before any change seen
  // this cycle, so a coincident event uses the old mode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DIGITO_STB <= 1'b0;
      DIGITO     <= 4'd0;
      MONTO_STB  <= 1'b0;
      MONTO      <= '0;
      acc        <= '0;
      dcnt       <= '0;
      modo_q     <= 1'b0;
    end else begin
      DIGITO_STB <= 1'b0;
      MONTO_STB  <= 1'b0;
      modo_q     <= MODO_MONTO;
      if (ev) begin
        if (!modo_q) begin
          if (es_digito(ev_code)) begin
            DIGITO_STB <= 1'b1;
            DIGITO     <= ev_code[3:0];
          end
        end else begin
          unique case (1'b1)
            es_digito(ev_code): begin
              if (dcnt < DCW'(MAX_DIG)) begin
                acc  <= acc_nx;
                dcnt <= dcnt + 1'b1;
              end
            end
            (ev_code == TECLA_ENTER): begin
              if (dcnt != '0) begin
                MONTO     <= acc;
                MONTO_STB <= 1'b1;
                acc       <= '0;
                dcnt      <= '0;
              end
            end
            (ev_code == TECLA_BORRAR): begin
              acc  <= '0;
              dcnt <= '0;
            end
            default: ;
          endcase
        end
      end
      if (MODO_MONTO != modo_q) begin
        acc  <= '0;
        dcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_teclado_cajero.sv
// Scoreboard bench for teclado_cajero with a keypad matrix model.
// Directed key sequences; a monitor checks every strobe against a queue.
module tb_teclado_cajero;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  COLUMNAS;
  logic [3:0]  FILAS;
  logic        MODO_MONTO = 1'b0;
  logic        DIGITO_STB;
  logic [3:0]  DIGITO;
  logic        MONTO_STB;
  logic [31:0] MONTO;

  logic [15:0] keys = 16'h0;

  teclado_cajero #(
    .SCAN_DIV    (2),
    .DEBOUNCE_CNT(3),
    .MAX_DIG     (8),
    .MONTO_W     (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .COLUMNAS  (COLUMNAS),
    .FILAS     (FILAS),
    .MODO_MONTO(MODO_MONTO),
    .DIGITO_STB(DIGITO_STB),
    .DIGITO    (DIGITO),
    .MONTO_STB (MONTO_STB),
    .MONTO     (MONTO)
  );

  initial forever #5 clock = ~clock;

  // Key at row r, col c is bit r*4+c; pressed keys short row to column.
  always_comb begin
    FILAS = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !COLUMNAS[c])
          FILAS[r] = 1'b0;
  end

  localparam int KD [10] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10};
  localparam int K_STAR = 12;
  localparam int K_HASH = 14;
  localparam int SCAN   = 8;

  typedef struct packed {
    logic        es_monto;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_dig   = 0;

  always @(negedge clock) begin
    if (reset) begin
      if (DIGITO_STB && MONTO_STB) begin
        n_tests++;
        n_fail++;
        $display("FAIL both_strobes: got 1/1, expected never both");
      end
      if (DIGITO_STB || MONTO_STB) begin
        n_tests++;
        if (DIGITO_STB) n_dig++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: dig_stb=%0b d=%0d monto_stb=%0b m=%0d, expected none",
                   DIGITO_STB, DIGITO, MONTO_STB, MONTO);
        end else begin
          e = q.pop_front();
          if (e.es_monto != MONTO_STB ||
              (MONTO_STB ? (MONTO != e.val)
                         : (DIGITO != e.val[3:0]))) begin
            n_fail++;
            $display("FAIL strobe_value: got monto_stb=%0b d=%0d m=%0d, expected monto_stb=%0b val=%0d",
                     MONTO_STB, DIGITO, MONTO, e.es_monto, e.val);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input logic m, input int v);
    exp_t x;
    x.es_monto = m;
    x.val      = 32'(v);
    q.push_back(x);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int b, input int hold, input int rel);
    keys    = 16'h0;
    keys[b] = 1'b1;
    cycles(hold * SCAN);
    keys = 16'h0;
    cycles(rel * SCAN);
  endtask

  task automatic tecla(input int b);
    press(b, 5, 6);
  endtask

  int d0;

  initial begin
    // Reset with a key held.
    keys  = 16'h0020;
    reset = 1'b0;
    cycles(3);
    chk("rst_columnas", COLUMNAS, 4'b1110);
    chk("rst_digito_stb", DIGITO_STB, 0);
    chk("rst_digito", DIGITO, 0);
    chk("rst_monto_stb", MONTO_STB, 0);
    chk("rst_monto", MONTO, 0);
    keys  = 16'h0;
    reset = 1'b1;
    cycles(3 * SCAN);

    // PIN mode: long hold gives one strobe, re-press gives another.
    MODO_MONTO = 1'b0;
    d0 = n_dig;
    expect_ev(1'b0, 5);
    press(KD[5], 8, 6);
    chk("pin_first_count", n_dig - d0, 1);
    expect_ev(1'b0, 5);
    press(KD[5], 8, 6);
    chk("pin_second_count", n_dig - d0, 2);

    // Bounce shorter than the debounce window, then two keys at once.
    press(KD[7], 2, 6);
    keys = 16'h0003;
    cycles(6 * SCAN);
    keys = 16'h0;
    cycles(6 * SCAN);
    chk("bounce_multi_no_strobe", n_dig - d0, 2);

    // Amount mode.
    MODO_MONTO = 1'b1;
    cycles(4);
    tecla(KD[2]);
    tecla(KD[5]);
    tecla(KD[0]);
    expect_ev(1'b1, 250);
    tecla(K_HASH);
    chk("monto_250", MONTO, 250);
    tecla(K_HASH);
    chk("empty_enter_holds", MONTO, 250);

    // Saturation at eight digits.
    for (int i = 0; i < 9; i++) tecla(KD[9]);
    expect_ev(1'b1, 99999999);
    tecla(K_HASH);
    chk("monto_saturado", MONTO, 99999999);

    // BORRAR clears the partial amount.
    tecla(KD[1]);
    tecla(KD[2]);
    tecla(K_STAR);
    tecla(KD[7]);
    expect_ev(1'b1, 7);
    tecla(K_HASH);
    chk("monto_borrar", MONTO, 7);

    // Mode toggle discards the partial amount.
    tecla(KD[3]);
    tecla(KD[4]);
    MODO_MONTO = 1'b0;
    cycles(4);
    MODO_MONTO = 1'b1;
    cycles(4);
    tecla(K_HASH);
    chk("mode_clear_monto", MONTO, 7);

    // Reset during debounce of '8'.
    keys    = 16'h0;
    keys[KD[8]] = 1'b1;
    cycles(12);
    reset = 1'b0;
    keys  = 16'h0;
    cycles(4);
    chk("rst_mid_monto", MONTO, 0);
    reset = 1'b1;
    cycles(6 * SCAN);
    chk("queue_drained", q.size(), 0);
    chk("final_dig_count", n_dig - d0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
